// File: rtl/act_unit_seq.sv
// Sequential activation stage: captures a full vector, applies bypass/ReLU/leaky/clipped ReLU
// LANES elements per cycle, then presents the result. Define ACT_LEAKY_EN to build the leaky shifter.
module act_unit_seq #(
  parameter int DATA_WIDTH = 8,
  parameter int SA_LENGTH  = 256,
  parameter int LANES      = 32,
  parameter int LEAK_SHIFT = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic signed [DATA_WIDTH-1:0] in [SA_LENGTH],
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         en,
  input  logic [1:0]                   mode,
  input  logic signed [DATA_WIDTH-1:0] clip,
  output logic signed [DATA_WIDTH-1:0] out [SA_LENGTH],
  output logic                         out_valid,
  input  logic                         out_ready
);

  localparam int BEATS = SA_LENGTH / LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  if (SA_LENGTH % LANES != 0) begin : g_bad_lanes
    $error("act_unit_seq: SA_LENGTH must be a multiple of LANES");
  end
  if (LEAK_SHIFT < 0 || LEAK_SHIFT >= DATA_WIDTH) begin : g_bad_shift
    $error("act_unit_seq: LEAK_SHIFT out of range");
  end

  typedef enum logic [1:0] {IDLE, PROCESS, DONE} state_t;

  state_t                         state, state_next;
  logic [BW-1:0]                  beat;
  logic signed [DATA_WIDTH-1:0]   hold_data [SA_LENGTH];
  logic                           hold_en;
  logic [1:0]                     hold_mode;
  logic signed [DATA_WIDTH-1:0]   hold_clip;

  // Written with if/else rather than ?: so the arithmetic shift never loses its signedness.
  function automatic logic signed [DATA_WIDTH-1:0] act_fn(
    input logic signed [DATA_WIDTH-1:0] x,
    input logic                         e,
    input logic [1:0]                   m,
    input logic signed [DATA_WIDTH-1:0] c
  );
    logic signed [DATA_WIDTH-1:0] r;
    r = '0;
    if (e) begin
      case (m)
        2'b00: r = x;
        2'b01: if (!x[DATA_WIDTH-1]) r = x;
`ifdef ACT_LEAKY_EN
        2'b10: if (x[DATA_WIDTH-1]) r = x >>> LEAK_SHIFT;
               else r = x;
`else
        2'b10: if (!x[DATA_WIDTH-1]) r = x;
`endif
        default: begin
          if (c[DATA_WIDTH-1] || x[DATA_WIDTH-1]) r = '0;
          else if (x > c) r = c;
          else r = x;
        end
      endcase
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      beat      <= '0;
      hold_en   <= 1'b0;
      hold_mode <= 2'b00;
      hold_clip <= '0;
      for (int i = 0; i < SA_LENGTH; i++) begin
        hold_data[i] <= '0;
        out[i]       <= '0;
      end
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (in_valid) begin
            beat      <= '0;
            hold_en   <= en;
            hold_mode <= mode;
            hold_clip <= clip;
            for (int i = 0; i < SA_LENGTH; i++) hold_data[i] <= in[i];
          end
        end
        PROCESS: begin
          // Only the lanes belonging to the current beat are updated.
          for (int i = 0; i < SA_LENGTH; i++) begin
            if (beat == BW'(i / LANES))
              out[i] <= act_fn(hold_data[i], hold_en, hold_mode, hold_clip);
          end
          beat <= beat + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = PROCESS;
      PROCESS: if (beat == BW'(BEATS - 1)) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

endmodule

// File: doc/act_unit_seq.md
# act_unit_seq

Sequential, parametrised activation stage placed between the systolic-array accumulator outputs and the next-layer buffer. It accepts a full SA_LENGTH vector through a valid/ready handshake. The vector is processed LANES elements per cycle through a selectable activation: bypass, ReLU, leaky ReLU or clipped ReLU. The completed vector is presented with its own valid/ready handshake.

## Interface
- DATA_WIDTH, 8, signed element width (two's complement)
- SA_LENGTH, 256, elements per vector
- LANES, 32, elements processed per cycle; SA_LENGTH % LANES must be 0, else elaboration error
- LEAK_SHIFT, 3, arithmetic right-shift applied to negatives in leaky mode
- BEATS (localparam), SA_LENGTH/LANES
- Clock and reset: one clock; reset is synchronous and active-low.
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in  in  signed [DATA_WIDTH-1:0] x SA_LENGTH  input vector
- in_valid  in  1  input vector valid
- in_ready  out  1  block can accept a vector
- en  in  1  activation enable, sampled with the vector
- mode  in  2  00 bypass, 01 ReLU, 10 leaky ReLU, 11 clipped ReLU; sampled with the vector
- clip  in  signed DATA_WIDTH  upper bound for mode 11; sampled with the vector
- out  out  signed [DATA_WIDTH-1:0] x SA_LENGTH  result vector (registered)
- out_valid  out  1  result vector valid
- out_ready  in  1  consumer accepts result

## Operation
- FSM states:
  - IDLE: in_ready=1. On in_valid, capture in/en/mode/clip into holding registers, clear the beat counter and go to PROCESS.
  - PROCESS: each cycle, write the chunk for the current beat (lanes beat*LANES .. beat*LANES+LANES-1) into out and increment the counter. After beat BEATS-1 is written, go to DONE.
  - DONE: out_valid=1. Hold out stable. On out_ready, go to IDLE.
- in_ready = (state==IDLE). out_valid = (state==DONE). A vector is never accepted in the same cycle that a result is consumed.
- Per-element function, with x as the captured element:
  - en=0: 0 for every mode.
  - 00: x.
  - 01: x<0 ? 0 : x.
  - 10: x<0 ? x>>>LEAK_SHIFT : x. The shift floors toward -inf, so -1 gives -1 and -16 with shift 3 gives -2.
  - 11: x<0 ? 0 : (x>clip ? clip : x). A negative clip is treated as 0, so every output is 0.
- All arithmetic stays at DATA_WIDTH. No overflow is possible.
- out elements not yet written in the current pass keep their previous values. out is meaningful only while out_valid=1.
- in, mode, clip and en changes after the accept cycle have no effect on the vector in flight.

## Timing
- Reset, checked at the clock edge while rst_n=0:
  - state = IDLE, beat counter = 0.
  - out = all zeros, out_valid = 0, in_ready = 1 from the first cycle after reset.
  - Holding registers are cleared.
- Latency: with the accept edge at cycle 0, chunks are written at the edges ending cycles 1..BEATS, and out_valid=1 from cycle BEATS+1.
- Throughput: with out_ready held high, one vector every BEATS+2 cycles.
- Backpressure: out_valid stays high and out is held for as long as out_ready=0.
- Reset mid-PROCESS or mid-DONE: the vector in flight is abandoned with no partial output. The block returns to the full reset values.
- BEATS=1 (LANES=SA_LENGTH): PROCESS lasts a single cycle.

## Configuration
- ACT_LEAKY_EN defined: mode 10 is leaky ReLU as specified, and the shifter is instantiated.
- ACT_LEAKY_EN undefined: no shifter logic. Mode 10 behaves exactly as mode 01 (ReLU). LEAK_SHIFT is ignored.

## Test plan
Bench parameters: DATA_WIDTH=8, SA_LENGTH=8, LANES=2, LEAK_SHIFT=3.
- Reset, ReLU: hold rst_n=0 for 2 cycles -> out all 0, out_valid=0, in_ready=1. Then send mode=01, in={-128,-1,0,1,5,-7,127,64}, en=1 -> out={0,0,0,1,5,0,127,64}, with out_valid rising exactly 5 cycles after the accept edge.
- Leaky ReLU: mode=10, in={-1,-8,-16,-128,3,0,-9,100} -> out={-1,-1,-2,-16,3,0,-2,100} with ACT_LEAKY_EN defined. Without the macro, out={0,0,0,0,3,0,0,100}.
- Clipped ReLU: mode=11, clip=6, in={-3,0,6,7,127,2,-128,5} -> out={0,0,6,6,6,2,0,5}. Repeat with clip=-4 -> out all 0.
- Enable low and bypass: en=0 with any mode -> out all 0. Then mode=00, en=1, in={-5,5,...} -> out equals in.
- Backpressure and sampling: hold out_ready=0 for 10 cycles -> out_valid, out and in_ready=0 stay stable. Change in/mode one cycle after accept -> the result reflects the captured values.
- Reset mid-PROCESS: assert rst_n=0 in the cycle after accept -> out all 0, out_valid never asserts, and the next vector completes normally.
